heart_beat_ctrl: RTL
====================

Name: heart_beat_ctrl

Overview:
Run/pause/step controller for the board's 0..N-1 heart-beat position counter.
- Derives a step tick from the system clock.
- Debounces the pause key, the step key and the direction switch.
- Sequences position updates and publishes the position, a one-cycle step strobe and a wrap strobe to the LED/segment display logic.
- Replaces the separate 1 Hz clock domain with a single-clock enable scheme.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
TICK_HZ, 1, step rate in RUN state; DIV = CLK_FREQ/TICK_HZ, must be >= 2
DEBOUNCE_MS, 20, key stable time; DB_CYC = (CLK_FREQ/1000)*DEBOUNCE_MS, must be >= 1
NUM_STEPS, 8, position modulus, 2..2**CNT_W
CNT_W, 4, position width

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous reset, active-high
key_pause_n_in  input  1  pause/resume key, raw, active-low
key_step_n_in  input  1  single-step key, raw, active-low
dir_sw_in  input  1  direction switch, raw; 1 = up, 0 = down
pos_out  output  CNT_W  current position, 0..NUM_STEPS-1
step_out  output  1  one-cycle strobe, asserted in the cycle pos_out changes
dir_out  output  1  direction applied to the current/last step
wrap_out  output  1  one-cycle strobe when a step wraps (7->0 up or 0->7 down for NUM_STEPS=8)
running_out  output  1  1 in RUN, 0 in STOP

Behaviour:
- Reset: asynchronous on rst_in high; all flops clear on rst_in assertion.
  - State = RUN, pos_out = 0, step_out = 0, wrap_out = 0, dir_out = 1, running_out = 1, prescaler = 0.
  - Debounced levels: keys released (1), direction = 1.
- Input conditioning:
  - Each raw input passes a 2-FF synchronizer, then a debouncer.
  - Accepted level updates only after DB_CYC consecutive cycles of a sample differing from the accepted level. Any bounce restarts the count.
  - A key press event is a 1-cycle pulse on an accepted 1->0 transition. Release generates nothing.
  - Direction has no event; its level is used directly.
- Prescaler:
  - Runs only in RUN. Counts 0..DIV-1 and asserts tick in the cycle it holds DIV-1, then returns to 0.
  - Forced to 0 while in STOP, so the first tick after resume occurs exactly DIV cycles after the RUN entry cycle.
- FSM states: RUN, STOP.
  - RUN + pause press -> STOP.
  - STOP + pause press -> RUN.
  - STOP + step press -> one step, remain in STOP.
  - RUN + step press -> ignored.
- Step source: tick in RUN, or step press in STOP. At most one step per cycle.
- Step arithmetic, registered; outputs change the cycle after the triggering event (1-cycle latency):
  - up: pos = (pos == NUM_STEPS-1) ? 0 : pos+1.
  - down: pos = (pos == 0) ? NUM_STEPS-1 : pos-1.
  - wrap_out asserts together with step_out on either wrap case.
  - dir_out is loaded from the debounced direction at each step.
- Simultaneous events:
  - tick and pause press in the same cycle: the step is issued, and the state becomes STOP in the same update.
  - pause press and step press in STOP in the same cycle: resume only, no step.
- Direction change mid-run takes effect at the next step. There is no prescaler reset on direction change.
- Reset mid-operation aborts any debounce in progress; pending press pulses are lost.
- pos_out never leaves 0..NUM_STEPS-1.

Decomposition:
- Shared package heart_beat_pkg:
  - state enum (RUN, STOP)
  - functions computing DIV and DB_CYC widths ($clog2)
  - default CNT_W/NUM_STEPS constants, also used by the display decoder
- Sub-module key_debounce (parameter DB_CYC):
  - synchronizer + stable counter
  - outputs level and press pulse
  - instantiated three times; the press output is unused for the direction switch.
- Top holds the prescaler, FSM and position register.

Test Plan:
All scenarios use CLK_FREQ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_MS=4 (DB_CYC=4), NUM_STEPS=8, CNT_W=4.
1. Release reset, dir=1, hold 85 cycles -> step_out pulses every 10 cycles; pos_out 1..7 then 0, with wrap_out on the 7->0 step only; running_out = 1.
2. dir=0 after reset -> first step gives pos_out = 7 with wrap_out = 1, next gives 6; dir_out = 0.
3. Pause key low with 3-cycle bounce glitches, then stable -> exactly one press pulse, STOP entered, no further steps. Three step presses give exactly three steps.
4. Pause pressed so its pulse coincides with tick -> one step issued and running_out = 0 in the same update. Resume -> next step exactly 10 cycles after RUN entry.
5. Step key pressed in RUN -> no extra step; step cadence unchanged.
6. Assert rst_in asynchronously mid-count at pos = 5 in STOP -> outputs immediately reset: pos_out = 0, running_out = 1, step_out = 0. Stepping resumes 10 cycles after rst_in deassertion.

Source files
------------

// File: rtl/heart_beat_pkg.sv
// Shared types and sizing helpers for the heart-beat position controller
// and the display logic that decodes its position.
package heart_beat_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } state_e;

    localparam int unsigned DEF_CNT_W     = 4;
    localparam int unsigned DEF_NUM_STEPS = 8;

    // Width of a counter holding 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned div_width(input int unsigned clk_freq,
                                              input int unsigned tick_hz);
        return cnt_width(clk_freq / tick_hz);
    endfunction

    function automatic int unsigned db_width(input int unsigned clk_freq,
                                             input int unsigned debounce_ms);
        return cnt_width((clk_freq / 1000) * debounce_ms);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stable-time debouncer for one raw input;
// publishes the accepted level and a one-cycle pulse on an accepted 1->0.
module key_debounce
    import heart_beat_pkg::*;
#(
    parameter int unsigned DB_CYC = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw_in,
    output logic level_out,
    output logic press_out
);

    localparam int unsigned CW = cnt_width(DB_CYC);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] stable_cnt;

    // Level flips on the DB_CYC-th consecutive differing sample; any match restarts
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q1    <= 1'b1;
            sync_q2    <= 1'b1;
            level_out  <= 1'b1;
            press_out  <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_q1   <= raw_in;
            sync_q2   <= sync_q1;
            press_out <= 1'b0;
            if (sync_q2 == level_out) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DB_CYC - 1)) begin
                level_out  <= sync_q2;
                press_out  <= ~sync_q2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/heart_beat_ctrl.sv
// Run/pause/step controller for the heart-beat position counter, driven
// from a single system clock with a tick enable instead of a 1 Hz domain.
module heart_beat_ctrl
    import heart_beat_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 12000000,
    parameter int unsigned TICK_HZ     = 1,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned NUM_STEPS   = DEF_NUM_STEPS,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             key_pause_n_in,
    input  logic             key_step_n_in,
    input  logic             dir_sw_in,
    output logic [CNT_W-1:0] pos_out,
    output logic             step_out,
    output logic             dir_out,
    output logic             wrap_out,
    output logic             running_out
);

    localparam int unsigned DIV    = CLK_FREQ / TICK_HZ;
    localparam int unsigned DB_CYC = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int unsigned DIV_W  = div_width(CLK_FREQ, TICK_HZ);

    localparam logic [CNT_W-1:0] POS_MAX   = CNT_W'(NUM_STEPS - 1);
    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(DIV - 1);

    logic pause_press;
    logic step_press;
    logic dir_level;
    logic pause_level_unused;
    logic step_level_unused;
    logic dir_press_unused;

    key_debounce #(.DB_CYC(DB_CYC)) u_db_pause (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .raw_in   (key_pause_n_in),
        .level_out(pause_level_unused),
        .press_out(pause_press)
    );

    key_debounce #(.DB_CYC(DB_CYC)) u_db_step (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .raw_in   (key_step_n_in),
        .level_out(step_level_unused),
        .press_out(step_press)
    );

    key_debounce #(.DB_CYC(DB_CYC)) u_db_dir (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .raw_in   (dir_sw_in),
        .level_out(dir_level),
        .press_out(dir_press_unused)
    );

    state_e           state;
    state_e           state_nxt;
    logic [DIV_W-1:0] presc;
    logic             tick;
    logic             do_step;

    // Pause toggles the state; in STOP a simultaneous step press is dropped
    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        do_step   = 1'b0;
        if (state == ST_RUN) begin
            tick    = (presc == PRESC_MAX);
            do_step = tick;
        end else begin
            do_step = step_press & ~pause_press;
        end
        if (pause_press) begin
            state_nxt = (state == ST_RUN) ? ST_STOP : ST_RUN;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= ST_RUN;
            presc       <= '0;
            pos_out     <= '0;
            step_out    <= 1'b0;
            wrap_out    <= 1'b0;
            dir_out     <= 1'b1;
            running_out <= 1'b1;
        end else begin
            state       <= state_nxt;
            running_out <= (state_nxt == ST_RUN);
            step_out    <= do_step;
            wrap_out    <= 1'b0;
            // Prescaler only advances across RUN->RUN cycles, so RUN entry sees zero
            if (state == ST_RUN && state_nxt == ST_RUN && !tick) begin
                presc <= presc + 1'b1;
            end else begin
                presc <= '0;
            end
            if (do_step) begin
                dir_out <= dir_level;
                if (dir_level) begin
                    wrap_out <= (pos_out == POS_MAX);
                    pos_out  <= (pos_out == POS_MAX) ? '0 : pos_out + 1'b1;
                end else begin
                    wrap_out <= (pos_out == '0);
                    pos_out  <= (pos_out == '0) ? POS_MAX : pos_out - 1'b1;
                end
            end
        end
    end

endmodule
